// File: rtl/seq_demux_pkg.sv
// seq_demux shared types: FSM state encoding and sel width helper.
// Optional feature macro: SEQ_DEMUX_PARITY_EN (trailing even-parity bit).
package seq_demux_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PAR   = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  function automatic int sel_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_demux_if.sv
// seq_demux handshake bundle: serial input side and parallel output side.
// Same signal set with or without SEQ_DEMUX_PARITY_EN.
interface seq_demux_if
  import seq_demux_pkg::*;
#(
  parameter int WIDTH = 4
);
  localparam int SW = sel_w(WIDTH);

  logic             din;
  logic             din_vld;
  logic             din_rdy;
  logic             clr;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic             dout_rdy;
  logic [SW-1:0]    sel;
  logic             par_err;

  modport master (
    output din, din_vld, clr, dout_rdy,
    input  din_rdy, dout, dout_vld, sel, par_err
  );

  modport slave (
    input  din, din_vld, clr, dout_rdy,
    output din_rdy, dout, dout_vld, sel, par_err
  );

endinterface

// File: rtl/seq_demux.sv
// Serial-to-parallel demux: bit k of a word lands in dout[k].
// Macro SEQ_DEMUX_PARITY_EN adds a trailing even-parity bit and par_err.
module seq_demux
  import seq_demux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic       clk,
  input logic       rst,
  seq_demux_if.slave bus
);

  localparam int SW = sel_w(WIDTH);

  localparam logic [1:0] IDLE  = S_IDLE;
  localparam logic [1:0] SHIFT = S_SHIFT;
  localparam logic [1:0] HOLD  = S_HOLD;
`ifdef SEQ_DEMUX_PARITY_EN
  localparam logic [1:0] PAR   = S_PAR;
`endif

  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

  logic [1:0]       state;
  logic [SW-1:0]    sel;
  logic [WIDTH-1:0] dout;
  logic             rdy_en;
  logic             acc;
  logic             par_err;

  assign bus.din_rdy  = rdy_en & (state != HOLD);
  assign acc          = bus.din_vld & bus.din_rdy;
  assign bus.dout     = dout;
  assign bus.dout_vld = (state == HOLD);
  assign bus.sel      = sel;
  assign bus.par_err  = par_err;

  // keep din_rdy low until the first edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_en <= 1'b0;
    else     rdy_en <= 1'b1;
  end

  // word assembly FSM; clr aborts without touching dout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel   <= '0;
      dout  <= '0;
    end else if (bus.clr) begin
      state <= IDLE;
      sel   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acc) begin
            dout  <= {{(WIDTH-1){1'b0}}, bus.din};
            sel   <= SW'(1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (acc) begin
            dout[sel] <= bus.din;
            if (sel == LAST) begin
              sel <= '0;
`ifdef SEQ_DEMUX_PARITY_EN
              state <= PAR;
`else
              state <= HOLD;
`endif
            end else begin
              sel <= sel + SW'(1);
            end
          end
        end
`ifdef SEQ_DEMUX_PARITY_EN
        PAR: begin
          if (acc) state <= HOLD;
        end
`endif
        HOLD: begin
          if (bus.dout_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEQ_DEMUX_PARITY_EN
  // capture parity check as the parity bit is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      par_err <= 1'b0;
    else if (!bus.clr && state == PAR && acc)
      par_err <= (^dout) ^ bus.din;
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: doc/seq_demux.md
SEQ_DEMUX -- requirements
Module: seq_demux

Interface
REQ-001 Parameter: WIDTH, 4, number of parallel output bits (legal range 2..64).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 din  input  1  serial data bit.
REQ-005 din_vld  input  1  din valid.
REQ-006 din_rdy  output  1  block can accept din this cycle.
REQ-007 clr  input  1  synchronous abort of the partial word.
REQ-008 dout  output  WIDTH  assembled parallel word.
REQ-009 dout_vld  output  1  dout complete and stable.
REQ-010 dout_rdy  input  1  consumer takes dout.
REQ-011 sel  output  $clog2(WIDTH)  index that the next accepted data bit writes.
REQ-012 par_err  output  1  parity mismatch flag, qualified by dout_vld.

Function
REQ-013 A bit is accepted only in a cycle where din_vld and din_rdy are both 1.
REQ-014 The k-th accepted data bit of a word (k = 0..WIDTH-1) SHALL be written to dout[k], so the first bit lands in dout[0].
REQ-015 On acceptance of bit 0, dout[WIDTH-1:1] SHALL clear to 0.
REQ-016 sel SHALL increment by 1 per accepted data bit and wrap from WIDTH-1 to 0 when the word completes.
REQ-017 FSM states: IDLE (sel=0, no bits held); SHIFT (partial word); PAR (awaiting parity bit, only when the macro is defined); HOLD (word complete).
REQ-018 Transitions: IDLE->SHIFT on acceptance of bit 0; SHIFT->HOLD (or ->PAR with the macro) on acceptance of bit WIDTH-1; PAR->HOLD on acceptance of the parity bit; HOLD->IDLE on dout_rdy=1.
REQ-019 din_rdy SHALL be 1 in IDLE, SHIFT and PAR, and 0 in HOLD.
REQ-020 dout_vld SHALL be 1 exactly while in HOLD, asserting the cycle after the final accepted bit (latency 1).
REQ-021 dout and par_err SHALL remain stable throughout HOLD.
REQ-022 If dout_rdy and din_vld are both 1 in HOLD, no bit SHALL be accepted that cycle; din_rdy rises in the following cycle (no bypass).
REQ-023 clr=1 in any state SHALL force IDLE with sel=0 and dout_vld=0, leaving dout unchanged; any bit presented that cycle SHALL be dropped.
REQ-024 Priority order: rst > clr > handshake.
REQ-025 If WIDTH is not a power of two, sel SHALL still wrap at WIDTH-1, never reaching WIDTH.

Reset
REQ-026 While rst=1, outputs SHALL be forced immediately, independent of clk: state=IDLE, sel=0, dout=0, dout_vld=0, par_err=0, din_rdy=0.
REQ-027 din_rdy SHALL rise to 1 on the first rising edge of clk after rst deasserts.
REQ-028 Reset asserted mid-word or in HOLD SHALL discard all partial or held data.

Configuration
REQ-029 Macro SEQ_DEMUX_PARITY_EN defined: after the WIDTH data bits, one additional even-parity bit is accepted in PAR.
REQ-030 With SEQ_DEMUX_PARITY_EN defined: par_err = (XOR of dout) XOR (parity bit), registered on entry to HOLD.
REQ-031 SEQ_DEMUX_PARITY_EN undefined: the PAR state is absent, SHIFT goes directly to HOLD, and par_err is constant 0.
REQ-032 The port list SHALL be identical with and without SEQ_DEMUX_PARITY_EN.

Structure
REQ-033 Package seq_demux_pkg SHALL hold the FSM state enum and a function returning the sel width for a given WIDTH.
REQ-034 The counter and FSM SHALL be implemented inline in seq_demux, with no sub-module.

Verification (WIDTH=4 unless noted)
REQ-035 Basic word: with din_vld held high, stream 1,0,1,1 -> dout=4'b1101; dout_vld=1 exactly one cycle after the 4th accepted bit; sel returns to 0.
REQ-036 Backpressure: hold dout_rdy=0 for 5 cycles with din_vld=1 -> din_rdy=0 throughout and no bit lost; after dout_rdy=1, the next word assembles correctly.
REQ-037 Abort: pulse clr after 2 accepted bits -> sel=0 and dout_vld=0; the following 4 bits 0,1,1,0 -> dout=4'b0110.
REQ-038 Async reset: assert rst mid-word between clock edges -> dout=0, sel=0, dout_vld=0 without waiting for a clock edge; the next full word assembles correctly.
REQ-039 With SEQ_DEMUX_PARITY_EN: data 1,0,1,1 with parity bit 1 -> par_err=0; with parity bit 0 -> par_err=1; dout=4'b1101 in both cases.
REQ-040 WIDTH=8: stream alternating 1,0 bits -> dout=8'h55; sel wraps 7->0 at word completion.
